// File: rtl/noc_router.sv
// noc_router: 5-port input-buffered mesh/torus router, XY routing, per-output round-robin.
// Define NOC_ROUTER_STATS_EN to add per-output forwarded-flit counters on stat_fwd.
module noc_router #(
    parameter int MESH_WIDTH  = 3,
    parameter int MESH_HEIGHT = 3,
    parameter int NODE_X      = 0,
    parameter int NODE_Y      = 0,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TORUS       = 0,
    localparam int XW     = (MESH_WIDTH > 1) ? $clog2(MESH_WIDTH) : 1,
    localparam int YW     = (MESH_HEIGHT > 1) ? $clog2(MESH_HEIGHT) : 1,
    localparam int FLIT_W = YW + XW + DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          in_valid,
    output logic [4:0]          in_ready,
    input  logic [5*FLIT_W-1:0] in_flit,
    output logic [4:0]          out_valid,
    input  logic [4:0]          out_ready,
    output logic [5*FLIT_W-1:0] out_flit,
`ifdef NOC_ROUTER_STATS_EN
    output logic [5*16-1:0]     stat_fwd,
`endif
    output logic [4:0]          drop_pulse
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] P_NORTH = 3'd0;
    localparam logic [2:0] P_SOUTH = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_WEST  = 3'd3;
    localparam logic [2:0] P_LOCAL = 3'd4;

    typedef logic [FLIT_W-1:0] flit_t;

    flit_t         mem_q [5][FIFO_DEPTH];
    flit_t         mem_d [5][FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q [5];
    logic [AW-1:0] rd_ptr_d [5];
    logic [AW-1:0] wr_ptr_q [5];
    logic [AW-1:0] wr_ptr_d [5];
    logic [CW-1:0] count_q [5];
    logic [CW-1:0] count_d [5];
    logic [4:0]    out_valid_q, out_valid_d;
    flit_t         out_flit_q [5];
    flit_t         out_flit_d [5];
    logic [2:0]    rr_ptr_q [5];
    logic [2:0]    rr_ptr_d [5];
    flit_t         head [5];
    logic [2:0]    route [5];
    logic [4:0]    head_valid, drop, granted, push;

    // Torus picks the shorter wrapped direction per dimension; ties go EAST/SOUTH.
    function automatic logic [2:0] route_fn(input logic [XW-1:0] dx, input logic [YW-1:0] dy);
        int x, y, fwd;
        x = int'(dx);
        y = int'(dy);
        route_fn = P_LOCAL;
        if (x != NODE_X) begin
            if (TORUS != 0) begin
                fwd = (x - NODE_X + MESH_WIDTH) % MESH_WIDTH;
                route_fn = (fwd <= MESH_WIDTH - fwd) ? P_EAST : P_WEST;
            end else begin
                route_fn = (x > NODE_X) ? P_EAST : P_WEST;
            end
        end else if (y != NODE_Y) begin
            if (TORUS != 0) begin
                fwd = (y - NODE_Y + MESH_HEIGHT) % MESH_HEIGHT;
                route_fn = (fwd <= MESH_HEIGHT - fwd) ? P_SOUTH : P_NORTH;
            end else begin
                route_fn = (y > NODE_Y) ? P_SOUTH : P_NORTH;
            end
        end
    endfunction

    always_comb begin
        logic       found;
        logic [2:0] winner;
        logic [2:0] cand;
        found       = 1'b0;
        winner      = '0;
        cand        = '0;
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_flit_d  = out_flit_q;
        rr_ptr_d    = rr_ptr_q;
        granted     = '0;

        for (int p = 0; p < 5; p++) begin
            head[p]       = mem_q[p][rd_ptr_q[p]];
            head_valid[p] = (count_q[p] != '0);
            drop[p]       = head_valid[p] &&
                            ((int'(head[p][DATA_WIDTH +: XW]) >= MESH_WIDTH) ||
                             (int'(head[p][DATA_WIDTH+XW +: YW]) >= MESH_HEIGHT));
            route[p]      = route_fn(head[p][DATA_WIDTH +: XW], head[p][DATA_WIDTH+XW +: YW]);
            push[p]       = in_valid[p] & in_ready[p];
        end

        for (int o = 0; o < 5; o++) begin
            found  = 1'b0;
            winner = '0;
            if (!out_valid_q[o] || out_ready[o]) begin
                for (int k = 0; k < 5; k++) begin
                    cand = 3'((int'(rr_ptr_q[o]) + k) % 5);
                    if (!found && head_valid[cand] && !drop[cand] && route[cand] == 3'(o)) begin
                        found  = 1'b1;
                        winner = cand;
                    end
                end
            end
            if (found) begin
                granted[winner] = 1'b1;
                out_valid_d[o]  = 1'b1;
                out_flit_d[o]   = head[winner];
                rr_ptr_d[o]     = (winner == 3'd4) ? 3'd0 : winner + 3'd1;
            end
        end

        for (int p = 0; p < 5; p++) begin
            if (push[p]) begin
                mem_d[p][wr_ptr_q[p]] = in_flit[p*FLIT_W +: FLIT_W];
                wr_ptr_d[p]           = wr_ptr_q[p] + AW'(1);
            end
            if (drop[p] || granted[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + AW'(1);
            end
            count_d[p] = count_q[p] + CW'(push[p]) - CW'(drop[p] | granted[p]);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            rd_ptr_q    <= '{default: '0};
            wr_ptr_q    <= '{default: '0};
            count_q     <= '{default: '0};
            out_flit_q  <= '{default: '0};
            rr_ptr_q    <= '{default: '0};
            out_valid_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_flit_q  <= out_flit_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_port
        assign in_ready[g]                  = (count_q[g] != CW'(FIFO_DEPTH));
        assign out_flit[g*FLIT_W +: FLIT_W] = out_flit_q[g];
    end
    assign out_valid  = out_valid_q;
    assign drop_pulse = drop;

`ifdef NOC_ROUTER_STATS_EN
    logic [15:0] stat_q [5];
    logic [15:0] stat_d [5];

    always_comb begin
        stat_d = stat_q;
        for (int o = 0; o < 5; o++) begin
            if (out_valid_q[o] && out_ready[o] && stat_q[o] != 16'hFFFF) begin
                stat_d[o] = stat_q[o] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '{default: '0};
        end else begin
            stat_q <= stat_d;
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_stat
        assign stat_fwd[g*16 +: 16] = stat_q[g];
    end
`endif

endmodule
